// File: rtl/fp_round_pack_pkg.sv
// ============================================================================
// Module      : fp_types (package)
// Description : Shared types and constants for the single-precision
//               normalize-round-pack stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_types;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [26:0] mant;   // carry, hidden, 23 fraction, guard, sticky
    } fp_ext_t;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } fp_rm_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } fp_rp_state_t;

    localparam logic [31:0] FP_QNAN       = 32'h7FC0_0000;
    localparam logic [31:0] FP_MAX_FINITE = 32'h7F7F_FFFF;
    localparam logic [4:0]  MAX_LSHIFT    = 5'd25;

endpackage

`default_nettype wire

// File: rtl/fp_round_pack_if.sv
// ============================================================================
// Module      : fp_round_pack_if
// Description : Operand-in / result-out handshake bundle. The in_rm field
//               exists only when FP_ROUND_MODES_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fp_round_pack_if;

    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [26:0] in_mant;
`ifdef FP_ROUND_MODES_EN
    logic [2:0]  in_rm;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    modport master (
        output in_valid, in_sign, in_exp, in_mant,
`ifdef FP_ROUND_MODES_EN
        output in_rm,
`endif
        output out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant,
`ifdef FP_ROUND_MODES_EN
        input  in_rm,
`endif
        input  out_ready,
        output in_ready, out_valid, out_result, out_flags
    );

endinterface

`default_nettype wire

// File: rtl/fp_round_pack_rounder.sv
// ============================================================================
// Module      : fp_rounder
// Description : Combinational round-increment, carry renormalize, pack and
//               overflow/underflow/inexact flag generation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_rounder
    import fp_types::*;
(
    input  wire logic              i_sign,
    input  wire logic signed [9:0] i_exp,
    input  wire logic [25:0]       i_mant,   // hidden, fraction, guard, sticky
    input  wire fp_rm_t            i_rm,
    output logic [31:0]            o_result,
    output fp_flags_t              o_flags
);

    logic              w_g, w_s, w_l, w_inexact, w_inc;
    logic [24:0]       w_rounded;
    logic              w_carry, w_hidden, w_ovf, w_to_max;
    logic [22:0]       w_frac;
    logic signed [9:0] w_exp_r;

    always_comb begin
        w_g       = i_mant[1];
        w_s       = i_mant[0];
        w_l       = i_mant[2];
        w_inexact = w_g | w_s;

        w_inc = w_g & (w_s | w_l);
        case (i_rm)
            RM_RTZ:  w_inc = 1'b0;
            RM_RDN:  w_inc = w_inexact & i_sign;
            RM_RUP:  w_inc = w_inexact & ~i_sign;
            RM_RMM:  w_inc = w_g;
            default: w_inc = w_g & (w_s | w_l);
        endcase

        w_rounded = {1'b0, i_mant[25:2]} + {24'd0, w_inc};
        w_carry   = w_rounded[24];
        w_hidden  = w_carry | w_rounded[23];
        w_frac    = w_carry ? w_rounded[23:1] : w_rounded[22:0];
        w_exp_r   = w_carry ? (i_exp + 10'sd1) : i_exp;
        w_ovf     = (w_exp_r >= 10'sd255);

        // Directed modes that round toward zero saturate to max finite
        w_to_max = (i_rm == RM_RTZ) |
                   ((i_rm == RM_RDN) & ~i_sign) |
                   ((i_rm == RM_RUP) &  i_sign);

        o_result = '0;
        o_flags  = '0;
        if (w_ovf) begin
            o_result          = w_to_max ? {i_sign, FP_MAX_FINITE[30:0]}
                                         : {i_sign, 8'hFF, 23'd0};
            o_flags.overflow  = 1'b1;
            o_flags.inexact   = 1'b1;
        end else begin
            o_result          = {i_sign, (w_hidden ? w_exp_r[7:0] : 8'h00), w_frac};
            o_flags.underflow = ~w_hidden & w_inexact;
            o_flags.inexact   = w_inexact;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_round_pack.sv
// ============================================================================
// Module      : fp_round_pack
// Description : Multi-cycle normalize-round-pack stage producing an IEEE-754
//               single with flags. Optional macro: FP_ROUND_MODES_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_round_pack
    import fp_types::*;
(
    input  wire logic      clk,
    input  wire logic      rst_n,
    fp_round_pack_if.slave bus
);

    fp_rp_state_t      r_state, w_state_next;
    logic              r_sign;
    logic signed [9:0] r_exp;
    logic [26:0]       r_mant;
    logic [4:0]        r_lsh_cnt;
    logic [31:0]       r_result;
    fp_flags_t         r_flags;
    logic              r_out_valid;

    fp_ext_t           w_in_op;
    logic              w_in_special;
    logic              w_norm_done;
    fp_rm_t            w_rm;
    logic [31:0]       w_rnd_result;
    fp_flags_t         w_rnd_flags;

    assign w_in_op      = '{sign: bus.in_sign, exp: bus.in_exp, mant: bus.in_mant};
    assign w_in_special = (w_in_op.exp == 8'hFF) || (w_in_op.mant == 27'd0);
    assign w_norm_done  = r_mant[25] || (r_exp == 10'sd1) || (r_lsh_cnt == MAX_LSHIFT);

`ifdef FP_ROUND_MODES_EN
    logic [2:0] r_rm;
    assign w_rm = fp_rm_t'(r_rm);
`else
    assign w_rm = RM_RNE;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:  if (bus.in_valid) w_state_next = w_in_special ? OUT : NORM;
            NORM:  if (!r_mant[26] && w_norm_done) w_state_next = ROUND;
            ROUND: w_state_next = OUT;
            OUT:   if (r_out_valid && bus.out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // out_valid is registered from the state, so it trails entry into OUT by a cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_mant      <= '0;
            r_lsh_cnt   <= '0;
            r_result    <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
`ifdef FP_ROUND_MODES_EN
            r_rm        <= 3'd0;
`endif
        end else begin
            r_out_valid <= (r_state == OUT) && !(r_out_valid && bus.out_ready);
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_sign    <= w_in_op.sign;
                        r_mant    <= w_in_op.mant;
                        r_exp     <= (w_in_op.exp == 8'h00) ? 10'sd1
                                                            : $signed({2'b00, w_in_op.exp});
                        r_lsh_cnt <= '0;
`ifdef FP_ROUND_MODES_EN
                        r_rm      <= bus.in_rm;
`endif
                        if (w_in_op.exp == 8'hFF) begin
                            r_result <= (|w_in_op.mant[24:2]) ? FP_QNAN
                                                              : {w_in_op.sign, 8'hFF, 23'd0};
                            r_flags  <= '0;
                        end else if (w_in_op.mant == 27'd0) begin
                            r_result <= {w_in_op.sign, 31'd0};
                            r_flags  <= '0;
                        end
                    end
                end
                NORM: begin
                    if (r_mant[26]) begin
                        r_mant <= {1'b0, r_mant[26:2], r_mant[1] | r_mant[0]};
                        r_exp  <= r_exp + 10'sd1;
                    end else if (!w_norm_done) begin
                        r_mant    <= {r_mant[25:0], 1'b0};
                        r_exp     <= r_exp - 10'sd1;
                        r_lsh_cnt <= r_lsh_cnt + 5'd1;
                    end
                end
                ROUND: begin
                    r_result <= w_rnd_result;
                    r_flags  <= w_rnd_flags;
                end
                default: ;
            endcase
        end
    end

    fp_rounder u_rounder (
        .i_sign   (r_sign),
        .i_exp    (r_exp),
        .i_mant   (r_mant[25:0]),
        .i_rm     (w_rm),
        .o_result (w_rnd_result),
        .o_flags  (w_rnd_flags)
    );

    assign bus.in_ready   = (r_state == IDLE);
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_result;
    assign bus.out_flags  = r_flags;

endmodule

`default_nettype wire

// File: doc/fp_round_pack.md
# fp_round_pack

Multi-cycle normalize-round-pack stage for single-precision results. It accepts an unrounded extended-precision result from an FPU datapath (add/sub/mul/div/sqrt/conv), normalizes it by iterative shifting, and rounds it. It then packs the value into a 32-bit IEEE-754 word with exception flags. It sits at the tail of the FPU, between the arithmetic units and writeback, and uses valid/ready handshakes on both sides.

## Interface
- No parameters (all widths fixed by `fp_types`).
- `clk` in 1: sole clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: extended operand valid.
- `in_ready` out 1: block can accept an operand; equals (state == IDLE).
- `in_sign` in 1: result sign.
- `in_exp` in 8: biased exponent. 0 with a nonzero mantissa is treated as 1.
- `in_mant` in 27: bit26 carry, bit25 hidden, bits24:2 fraction, bit1 guard, bit0 sticky.
- `in_rm` in 3: rounding mode. Present only with `FP_ROUND_MODES_EN`.
- `out_valid` out 1: packed result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_result` out 32: IEEE-754 single.
- `out_flags` out 3: {overflow, underflow, inexact}.

## Operation
- FSM states are IDLE, NORM, ROUND, OUT.
- Reset (asynchronous): state IDLE, out_valid 0, out_result 0, out_flags 0, in_ready 1. Reset asserted mid-operation abandons the job immediately.
- **IDLE.** On in_valid, capture the operand with the exponent extended to a 10-bit signed internal exponent.
  - in_exp = 0xFF, fraction nonzero: result 0x7FC00000, flags 0, go to OUT.
  - in_exp = 0xFF, fraction zero: result {sign, 0xFF, 0}, flags 0, go to OUT.
  - in_mant = 0: result {sign, 31'b0}, flags 0, go to OUT.
  - Otherwise go to NORM.
- **NORM.** One action per cycle, in priority order:
  - mant[26]=1: shift right 1, OR the shifted-out bit into bit0, exp+1.
  - else mant[25]=1: go to ROUND.
  - else exp == 1: go to ROUND as a subnormal.
  - else: shift left 1, exp-1.
  - At most 25 left shifts.
- **ROUND.** Computed combinationally in one cycle.
  - G = mant[1], S = mant[0], L = mant[2].
  - RNE increments at bit2 when G & (S | L).
  - A carry into bit26 renormalizes with a right shift and exp+1.
  - inexact = G | S.
  - If exp ≥ 255 after rounding: overflow=1, inexact=1, result ±infinity.
  - Otherwise the exponent field is exp[7:0] if mant[25] = 1, else 0.
  - underflow = (result subnormal or zero after rounding) & inexact.
  - Register result and flags, go to OUT.
- **OUT.** out_valid = 1. out_result and out_flags are held stable until out_ready, then go to IDLE. in_ready = 0 in NORM, ROUND and OUT.

## Timing
- The accept edge is E0. Normal path: out_valid rises after edge E(3+k), where k is the number of NORM shifts. Already-normalized input: 3 cycles; carry input: 4 cycles; worst case: 28 cycles.
- Special-value path (NaN, infinity, zero): out_valid rises after E1.
- Output handshake completes on an edge with out_valid & out_ready. in_ready rises the following cycle, giving one bubble per job.
- There are no combinational paths from in_valid to in_ready or from out_ready to out_valid.

## Configuration
- `FP_ROUND_MODES_EN` defined:
  - The `in_rm` port exists and is captured at accept.
  - Modes: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; other codes behave as RNE.
  - Directed modes increment when (G | S) and the sign matches the direction.
  - Overflow under RTZ, or under a directed mode rounding away from infinity, yields ±0x7F7FFFFF (max finite) with overflow=1 and inexact=1.
- `FP_ROUND_MODES_EN` undefined: the `in_rm` port is absent and RNE is hard-wired.

## Structure
- Package `fp_types` gains:
  - `fp_ext_t` (sign, 8-bit exp, 27-bit mant in the layout above).
  - `fp_rm_t` rounding-mode enum.
  - `fp_flags_t` {overflow, underflow, inexact}.
  - Constants `FP_QNAN` = 0x7FC00000 and `FP_MAX_FINITE` = 0x7F7FFFFF.
- One combinational sub-module, `fp_rounder`: round-increment decision, mantissa increment, carry renormalize, and overflow/underflow flag generation. The parent keeps the FSM and shift registers.

## Test plan
- sign 0, exp 0x7F, mant 0x2000000 -> 0x3F800000, flags 000, out_valid 3 cycles after accept.
- exp 0x7F, mant 0x4000000 -> 0x40000000, flags 000, latency 4.
- exp 0x7F, mant 0x3FFFFFE (all fraction ones, G=1, S=0) under RNE -> carry out, 0x40000000, flags 001.
- exp 0xFE, mant 0x4000000 -> 0x7F800000, flags 101. With `FP_ROUND_MODES_EN` and rm=RTZ -> 0x7F7FFFFF, flags 101.
- exp 0x01, mant 0x1000000 -> 0x00400000, flags 000, latency 3. exp 0x01, mant 0x0000003 -> 0x00000001, flags 011.
- exp 0xFF, mant 0x0000004 -> 0x7FC00000 after 1 cycle.
  - Hold out_ready=0 for 10 cycles: result stable, in_ready 0.
  - Pull rst_n low during NORM: out_valid 0, out_result 0, in_ready 1 without waiting for a clock edge.
